// File: rtl/store_buffer_if.sv
// store_buffer_if: core <-> store buffer <-> data memory signal bundle.
//   st_*  : store request channel (valid/ready, word-aligned addr, data, byte enables)
//   ld_*  : load request, returned word, stall back to the core
//   mem_* : single shared data-memory port (sync write, combinational read)
// Modports:
//   slave  - the store buffer itself
//   master - the environment (core + memory) driving the buffer
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_rdata;
  logic        ld_stall;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be, ld_req, ld_addr, mem_rd,
    output st_ready, ld_rdata, ld_stall, mem_we, mem_a, mem_wd
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_be, ld_req, ld_addr, mem_rd,
    input  st_ready, ld_rdata, ld_stall, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry FIFO write buffer in front of a word-addressed
// data memory. Stores are queued with byte enables and retired one per cycle
// as a read-modify-write on the shared memory port; loads take priority on
// that port and are stalled while they hit a pending store or the buffer is
// full.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   bus       - store_buffer_if.slave (store, load and memory channels)
//   count     - number of valid entries
//   empty     - count == 0

// One byte lane of the retire merge: take the queued byte where enabled,
// otherwise keep the byte currently in memory.
module sb_lane (
  input  logic       en,
  input  logic [7:0] sbyte,
  input  logic [7:0] rbyte,
  output logic [7:0] mbyte
);
  assign mbyte = en ? sbyte : rbyte;
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus,
  output logic [CW-1:0]  count,
  output logic           empty
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0]     waddr;
    logic [3:0][7:0] data;
    logic [3:0]      be;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head, tail;

  logic             full, hit, push, drain, served;
  logic [DEPTH-1:0] hit_vec;
  logic [3:0][7:0]  merged;
  entry_t           hd;

  // address bits [1:0] never take part in word addressing
  logic unused_lsbs;
  assign unused_lsbs = &{1'b0, bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign hd    = ent[head];

  // Only entries already in the queue are compared; a store pushed in the
  // same cycle is younger than the load and must not stall it.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit_vec[i] = vld[i] && (ent[i].waddr == bus.ld_addr[31:2]);
  end
  assign hit = |hit_vec;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    sb_lane u_lane (
      .en    (hd.be[b]),
      .sbyte (hd.data[b]),
      .rbyte (bus.mem_rd[8*b +: 8]),
      .mbyte (merged[b])
    );
  end

  assign bus.st_ready = !full;
  assign bus.ld_stall = bus.ld_req && (full || hit);
  // rst gating keeps the memory port quiet while reset is held, even if the
  // core is still presenting a load.
  assign served = !rst && bus.ld_req && !bus.ld_stall;
  assign drain  = !empty && (!bus.ld_req || bus.ld_stall);
  assign push   = bus.st_valid && bus.st_ready && (bus.st_be != 4'h0);

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_a    = '0;
    bus.mem_wd   = '0;
    bus.ld_rdata = '0;
    if (served) begin
      bus.mem_a    = {bus.ld_addr[31:2], 2'b00};
      bus.ld_rdata = bus.mem_rd;
    end else if (drain) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = {hd.waddr, 2'b00};
      bus.mem_wd = merged;
    end
  end

  // Payload needs no reset: an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail] <= '{waddr: bus.st_addr[31:2], data: bus.st_wdata, be: bus.st_be};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // push and drain never touch the same slot: that needs head == tail,
      // i.e. empty (no drain) or full (no push).
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (drain) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
